// File: rtl/ethernet_tx_arbiter_if.sv
// Stream bundle between the IP/ARP transmitters, the TX arbiter and the TEMAC.
// Every stream moves one beat on a rising clock edge where tvalid & tready are both high.
// tvalid must not wait for tready, and a sender holds tdata/tlast stable until the beat moves.
interface ethernet_tx_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  ip_tx_tvalid;
    logic [DATA_WIDTH-1:0] ip_tx_tdata;
    logic                  ip_tx_tlast;
    logic                  ip_tx_tready;
    logic [47:0]           ip_tx_dest_mac;

    logic                  arp_tx_tvalid;
    logic [DATA_WIDTH-1:0] arp_tx_tdata;
    logic                  arp_tx_tlast;
    logic                  arp_tx_tready;
    logic [47:0]           arp_tx_dest_mac;

    logic                  temac_tx_tvalid;
    logic [DATA_WIDTH-1:0] temac_tx_tdata;
    logic                  temac_tx_tlast;
    logic                  temac_tx_tready;

    // Requester and TEMAC side (testbench / surrounding system)
    modport master (
        output ip_tx_tvalid, ip_tx_tdata, ip_tx_tlast, ip_tx_dest_mac,
        input  ip_tx_tready,
        output arp_tx_tvalid, arp_tx_tdata, arp_tx_tlast, arp_tx_dest_mac,
        input  arp_tx_tready,
        input  temac_tx_tvalid, temac_tx_tdata, temac_tx_tlast,
        output temac_tx_tready
    );

    // Arbiter side
    modport slave (
        input  ip_tx_tvalid, ip_tx_tdata, ip_tx_tlast, ip_tx_dest_mac,
        output ip_tx_tready,
        input  arp_tx_tvalid, arp_tx_tdata, arp_tx_tlast, arp_tx_dest_mac,
        output arp_tx_tready,
        output temac_tx_tvalid, temac_tx_tdata, temac_tx_tlast,
        input  temac_tx_tready
    );
endinterface

// File: rtl/ethernet_tx_arbiter.sv
// Per-frame round-robin arbiter sharing the TEMAC TX stream between IP and ARP senders.
// Adds the 14-byte Ethernet header and zero-pads short frames up to MIN_FRAME_BYTES.
module ethernet_tx_arbiter #(
    parameter int          DATA_WIDTH      = 8,
    parameter int          MIN_FRAME_BYTES = 60,
    parameter logic [15:0] IP_HEADER_TYPE  = 16'h0800,
    parameter logic [15:0] ARP_HEADER_TYPE = 16'h0806
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [47:0]             temac_address,
    ethernet_tx_arbiter_if.slave    bus,
    output logic                    busy,
    output logic [1:0]              active_source,
    output logic [15:0]             ip_frame_count,
    output logic [15:0]             arp_frame_count,
    output logic [1:0]              fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        PAD     = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  grant_arp;
    logic                  last_grant_arp;
    logic                  grant_next_arp;
    logic [15:0]           byte_count;
    logic [111:0]          header_q;

    logic                  request;
    logic                  xfer;
    logic                  src_tvalid;
    logic [DATA_WIDTH-1:0] src_tdata;
    logic                  src_tlast;
    logic                  min_reached;
    logic                  pad_last;

    assign fsm_state = state;
    assign request   = bus.ip_tx_tvalid | bus.arp_tx_tvalid;

    // On a tie the source that did not win last time gets the bus.
    assign grant_next_arp = bus.arp_tx_tvalid & (~bus.ip_tx_tvalid | ~last_grant_arp);

    assign src_tvalid  = grant_arp ? bus.arp_tx_tvalid : bus.ip_tx_tvalid;
    assign src_tdata   = grant_arp ? bus.arp_tx_tdata  : bus.ip_tx_tdata;
    assign src_tlast   = grant_arp ? bus.arp_tx_tlast  : bus.ip_tx_tlast;
    assign min_reached = ({1'b0, byte_count} + 17'd1) >= 17'(MIN_FRAME_BYTES);
    assign pad_last    = byte_count == 16'(MIN_FRAME_BYTES - 1);
    assign xfer        = bus.temac_tx_tvalid & bus.temac_tx_tready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (request) state_next = HEADER;
            HEADER:  if (xfer && byte_count == 16'd13) state_next = PAYLOAD;
            PAYLOAD: if (xfer && src_tlast) state_next = min_reached ? IDLE : PAD;
            PAD:     if (xfer && pad_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.temac_tx_tvalid = 1'b0;
        bus.temac_tx_tdata  = '0;
        bus.temac_tx_tlast  = 1'b0;
        bus.ip_tx_tready    = 1'b0;
        bus.arp_tx_tready   = 1'b0;
        busy                = state != IDLE;
        active_source       = 2'b00;
        case (state)
            HEADER: begin
                bus.temac_tx_tvalid = 1'b1;
                bus.temac_tx_tdata  = header_q[111:104];
            end
            PAYLOAD: begin
                bus.temac_tx_tvalid = src_tvalid;
                bus.temac_tx_tdata  = src_tdata;
                bus.temac_tx_tlast  = src_tlast & min_reached;
                if (grant_arp) begin
                    bus.arp_tx_tready = bus.temac_tx_tready;
                end else begin
                    bus.ip_tx_tready = bus.temac_tx_tready;
                end
            end
            PAD: begin
                bus.temac_tx_tvalid = 1'b1;
                bus.temac_tx_tlast  = pad_last;
            end
            default: ;
        endcase
        if (state != IDLE) begin
            active_source = grant_arp ? 2'b10 : 2'b01;
        end
    end

    // Header is shifted out MSB first, so the next header byte is always header_q[111:104].
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_arp       <= 1'b0;
            last_grant_arp  <= 1'b1;
            byte_count      <= 16'd0;
            header_q        <= '0;
            ip_frame_count  <= 16'd0;
            arp_frame_count <= 16'd0;
        end else if (state == IDLE) begin
            if (request) begin
                grant_arp      <= grant_next_arp;
                last_grant_arp <= grant_next_arp;
                byte_count     <= 16'd0;
                header_q       <= grant_next_arp
                                ? {bus.arp_tx_dest_mac, temac_address, ARP_HEADER_TYPE}
                                : {bus.ip_tx_dest_mac,  temac_address, IP_HEADER_TYPE};
            end
        end else if (xfer) begin
            if (byte_count != 16'hFFFF) begin
                byte_count <= byte_count + 16'd1;
            end
            header_q <= {header_q[103:0], 8'h00};
            if (bus.temac_tx_tlast) begin
                if (grant_arp) begin
                    arp_frame_count <= arp_frame_count + 16'd1;
                end else begin
                    ip_frame_count <= ip_frame_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ethernet_tx_arbiter.sv
// Directed bench for ethernet_tx_arbiter: expected frames are queued as stimulus is issued
// and popped by a monitor on every TEMAC beat; status outputs are checked between steps.
module tb_ethernet_tx_arbiter;

    localparam int          MIN_BYTES = 60;
    localparam int          W         = 13;
    localparam logic [47:0] LOCAL_MAC = 48'h020000000001;
    localparam logic [1:0]  K_HDR     = 2'd0;
    localparam logic [1:0]  K_PAY     = 2'd1;
    localparam logic [1:0]  K_PAD     = 2'd2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] temac_address;
    logic        busy;
    logic [1:0]  active_source;
    logic [15:0] ip_frame_count;
    logic [15:0] arp_frame_count;
    logic [1:0]  fsm_state;

    ethernet_tx_arbiter_if bus ();

    ethernet_tx_arbiter dut (
        .clock           (clock),
        .reset           (reset),
        .temac_address   (temac_address),
        .bus             (bus.slave),
        .busy            (busy),
        .active_source   (active_source),
        .ip_frame_count  (ip_frame_count),
        .arp_frame_count (arp_frame_count),
        .fsm_state       (fsm_state)
    );

    always #5 clock = ~clock;

    // Each entry: {kind, owning source, tlast, data}
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_beat;
    int           compared = 0;
    int           mismatched = 0;
    int           cyc = 0;
    int           mon_beats = 0;
    int           last_tlast_cyc = -1;
    bit           first_beat = 1'b1;
    bit           gap_check = 1'b0;
    bit           stall_check = 1'b0;
    bit           prev_stall = 1'b0;
    logic [7:0]   prev_data;
    bit           abort = 1'b0;
    bit           tog_done = 1'b0;
    int           exp_ip = 0;
    int           exp_arp = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: one queue entry per TEMAC transfer, plus stall-hold and frame-gap checks.
    always @(negedge clock) begin
        if (!reset && bus.temac_tx_tvalid && bus.temac_tx_tready) begin
            mon_beats++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $error("FAIL unexpected_beat: observed data %0h with empty queue", bus.temac_tx_tdata);
            end else begin
                exp_beat = exp_q.pop_front();
                check("beat", {active_source, bus.temac_tx_tlast, bus.temac_tx_tdata}, exp_beat[10:0]);
                if (exp_beat[12:11] != K_PAY) begin
                    check("src_tready_outside_payload", {bus.ip_tx_tready, bus.arp_tx_tready}, 2'b00);
                end
                if (first_beat && gap_check && last_tlast_cyc >= 0) begin
                    check("frame_gap", cyc - last_tlast_cyc, 2);
                end
                first_beat = bus.temac_tx_tlast;
                if (bus.temac_tx_tlast) last_tlast_cyc = cyc;
            end
        end
        if (stall_check && prev_stall) begin
            check("stall_hold", {bus.temac_tx_tvalid, bus.temac_tx_tdata}, {1'b1, prev_data});
        end
        prev_stall = stall_check && bus.temac_tx_tvalid && !bus.temac_tx_tready;
        prev_data  = bus.temac_tx_tdata;
    end

    task automatic push_frame(input logic [1:0] src, input logic [47:0] dest,
                              input logic [15:0] etype, input int len, input logic [7:0] start);
        logic [111:0] hdr;
        logic [7:0]   data;
        logic [1:0]   kind;
        int           total;
        hdr   = {dest, LOCAL_MAC, etype};
        total = (14 + len < MIN_BYTES) ? MIN_BYTES : 14 + len;
        for (int i = 0; i < total; i++) begin
            if (i < 14) begin
                kind = K_HDR;
                data = hdr[111 - 8 * i -: 8];
            end else if (i < 14 + len) begin
                kind = K_PAY;
                data = start + 8'(i - 14);
            end else begin
                kind = K_PAD;
                data = 8'h00;
            end
            exp_q.push_back({kind, src, (i == total - 1), data});
        end
    endtask

    // sel = 0 drives the IP requester, sel = 1 the ARP requester.
    task automatic send(input bit sel, input int len, input logic [7:0] start, input bit gaps);
        bit hs;
        int n;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                if (sel) bus.arp_tx_tvalid = 1'b0; else bus.ip_tx_tvalid = 1'b0;
                @(posedge clock); #1;
            end
            if (sel) begin
                bus.arp_tx_tvalid = 1'b1;
                bus.arp_tx_tdata  = start + 8'(i);
                bus.arp_tx_tlast  = (i == len - 1);
            end else begin
                bus.ip_tx_tvalid = 1'b1;
                bus.ip_tx_tdata  = start + 8'(i);
                bus.ip_tx_tlast  = (i == len - 1);
            end
            n = 0;
            do begin
                @(negedge clock);
                hs = sel ? bus.arp_tx_tready : bus.ip_tx_tready;
                @(posedge clock); #1;
                n++;
                if (abort) return;
            end while (!hs && n < 4000);
            if (!hs) begin
                compared++;
                mismatched++;
                $error("FAIL handshake_timeout: source %0d byte %0d never accepted, required acceptance", sel, i);
                return;
            end
        end
        if (sel) begin
            bus.arp_tx_tvalid = 1'b0;
            bus.arp_tx_tlast  = 1'b0;
        end else begin
            bus.ip_tx_tvalid = 1'b0;
            bus.ip_tx_tlast  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            @(posedge clock); #1;
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_counts(input string tag);
        @(negedge clock);
        check({tag, "_ip_count"}, ip_frame_count, 16'(exp_ip));
        check({tag, "_arp_count"}, arp_frame_count, 16'(exp_arp));
        check({tag, "_idle_state"}, {busy, active_source, fsm_state}, 5'b0);
    endtask

    initial begin
        temac_address       = LOCAL_MAC;
        bus.ip_tx_tvalid    = 1'b0;
        bus.ip_tx_tdata     = '0;
        bus.ip_tx_tlast     = 1'b0;
        bus.ip_tx_dest_mac  = 48'h0A0B0C0D0E0F;
        bus.arp_tx_tvalid   = 1'b0;
        bus.arp_tx_tdata    = '0;
        bus.arp_tx_tlast    = 1'b0;
        bus.arp_tx_dest_mac = 48'hFFFFFFFFFFFF;
        bus.temac_tx_tready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("reset_tvalid", bus.temac_tx_tvalid, 1'b0);
        check("reset_src_tready", {bus.ip_tx_tready, bus.arp_tx_tready}, 2'b00);
        check_counts("reset");

        // 1: single IP frame of exactly minimum size
        push_frame(2'b01, 48'h0A0B0C0D0E0F, 16'h0800, 46, 8'h00);
        send(1'b0, 46, 8'h00, 1'b0);
        wait_idle();
        exp_ip++;
        check_counts("t1");

        // 2: short ARP frame with source gaps, padded
        push_frame(2'b10, 48'hFFFFFFFFFFFF, 16'h0806, 28, 8'h50);
        send(1'b1, 28, 8'h50, 1'b1);
        wait_idle();
        exp_arp++;
        check_counts("t2");

        // 3: simultaneous continuous requests alternate IP, ARP, IP, ARP
        push_frame(2'b01, 48'h0A0B0C0D0E0F, 16'h0800, 30, 8'h40);
        push_frame(2'b10, 48'hFFFFFFFFFFFF, 16'h0806, 28, 8'h80);
        push_frame(2'b01, 48'h0A0B0C0D0E0F, 16'h0800, 50, 8'h10);
        push_frame(2'b10, 48'hFFFFFFFFFFFF, 16'h0806, 28, 8'hC0);
        gap_check      = 1'b1;
        last_tlast_cyc = -1;
        fork
            begin
                send(1'b0, 30, 8'h40, 1'b0);
                send(1'b0, 50, 8'h10, 1'b0);
            end
            begin
                send(1'b1, 28, 8'h80, 1'b0);
                send(1'b1, 28, 8'hC0, 1'b0);
            end
        join
        wait_idle();
        gap_check = 1'b0;
        exp_ip  += 2;
        exp_arp += 2;
        check_counts("t3");

        // 4: case 1 again with TEMAC ready toggling every cycle
        push_frame(2'b01, 48'h0A0B0C0D0E0F, 16'h0800, 46, 8'h00);
        stall_check = 1'b1;
        tog_done    = 1'b0;
        fork
            begin
                send(1'b0, 46, 8'h00, 1'b0);
                tog_done = 1'b1;
            end
            begin
                while (!tog_done) begin
                    @(posedge clock); #1;
                    bus.temac_tx_tready = ~bus.temac_tx_tready;
                end
            end
        join
        bus.temac_tx_tready = 1'b1;
        wait_idle();
        stall_check = 1'b0;
        prev_stall  = 1'b0;
        exp_ip++;
        check_counts("t4");

        // 6: one-byte payload (45 pad bytes) and a 1500-byte payload (no pad)
        push_frame(2'b01, 48'h0A0B0C0D0E0F, 16'h0800, 1, 8'hA5);
        send(1'b0, 1, 8'hA5, 1'b0);
        wait_idle();
        exp_ip++;
        push_frame(2'b01, 48'h0A0B0C0D0E0F, 16'h0800, 1500, 8'h07);
        mon_beats = 0;
        send(1'b0, 1500, 8'h07, 1'b0);
        wait_idle();
        check("t6_long_frame_beats", mon_beats, 1514);
        exp_ip++;
        check_counts("t6");

        // 5: reset while IP byte 20 is pending, then a clean ARP frame
        push_frame(2'b01, 48'h0A0B0C0D0E0F, 16'h0800, 46, 8'h00);
        mon_beats = 0;
        fork
            send(1'b0, 46, 8'h00, 1'b0);
        join_none
        begin
            int n;
            n = 0;
            while (mon_beats < 20 && n < 2000) begin
                @(posedge clock); #2;
                n++;
            end
        end
        check("t5_beats_before_reset", mon_beats, 20);
        bus.temac_tx_tready = 1'b0;
        bus.ip_tx_tvalid    = 1'b0;
        bus.ip_tx_tlast     = 1'b0;
        abort = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        exp_q.delete();
        first_beat = 1'b1;
        exp_ip  = 0;
        exp_arp = 0;
        @(negedge clock);
        check("t5_tvalid_after_reset", bus.temac_tx_tvalid, 1'b0);
        check("t5_tlast_after_reset", bus.temac_tx_tlast, 1'b0);
        check_counts("t5_reset");
        abort = 1'b0;
        bus.temac_tx_tready = 1'b1;
        push_frame(2'b10, 48'hFFFFFFFFFFFF, 16'h0806, 28, 8'h33);
        send(1'b1, 28, 8'h33, 1'b0);
        wait_idle();
        exp_arp++;
        check_counts("t5_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ethernet_tx_arbiter.md
Name: ethernet_tx_arbiter

Overview:
- Transmit-side counterpart of the Ethernet receive path: shares the single TEMAC TX AXI-Stream between the IP and ARP transmitters.
- Arbitrates per frame, round-robin. Prepends the 14-byte Ethernet header (destination MAC, source MAC, EtherType) and zero-pads frames to the Ethernet minimum before handing them to the TEMAC, which appends the FCS.

Parameters:
DATA_WIDTH, 8, bits per stream beat (one octet)
MIN_FRAME_BYTES, 60, minimum frame length excluding FCS (header + payload + pad)
IP_HEADER_TYPE, 16'h0800, EtherType inserted for IP frames
ARP_HEADER_TYPE, 16'h0806, EtherType inserted for ARP frames

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
temac_address  in  48  local (source) MAC address
ip_tx_tvalid  in  1  IP payload byte valid
ip_tx_tdata  in  8  IP payload byte
ip_tx_tlast  in  1  last IP payload byte
ip_tx_tready  out  1  IP payload byte accepted
ip_tx_dest_mac  in  48  destination MAC for the IP frame; stable from first tvalid to tlast
arp_tx_tvalid  in  1  ARP payload byte valid
arp_tx_tdata  in  8  ARP payload byte
arp_tx_tlast  in  1  last ARP payload byte
arp_tx_tready  out  1  ARP payload byte accepted
arp_tx_dest_mac  in  48  destination MAC for the ARP frame; same stability rule
temac_tx_tvalid  out  1  frame byte valid to TEMAC
temac_tx_tdata  out  8  frame byte
temac_tx_tlast  out  1  last frame byte
temac_tx_tready  in  1  TEMAC accepts byte
busy  out  1  a frame is in progress (state != IDLE)
active_source  out  2  01 = IP owns the bus, 10 = ARP owns it, 00 = idle
ip_frame_count  out  16  completed IP frames, wraps
arp_frame_count  out  16  completed ARP frames, wraps

Behaviour:
- Reset (sync, active-high):
  - State goes to IDLE; last_grant = ARP, so IP wins the first tie.
  - Byte counter = 0; both frame counts = 0.
  - All outputs 0.
  - Reset mid-frame abandons the frame: no tlast is emitted, and the requester is not acknowledged further.
- States: IDLE, HEADER, PAYLOAD, PAD.
- Outputs are combinational from registered state/counters and requester inputs. temac_tx_tvalid never depends on temac_tx_tready.
- A beat transfers when temac_tx_tvalid & temac_tx_tready.
- IDLE:
  - A request is the requester's tvalid.
  - One requester: grant it. Both: grant the one not equal to last_grant.
  - On grant, latch the requester's dest MAC and temac_address, load EtherType, clear the byte counter, update last_grant, go to HEADER.
  - Grant decision takes 1 cycle; the first header byte is presented the following cycle.
  - Outputs: tvalid = 0, both tready = 0.
- HEADER:
  - tvalid = 1. Bytes 0-5: dest MAC, bits 47:40 first. Bytes 6-11: source MAC, same order. Bytes 12-13: EtherType, high byte first.
  - Counter increments per transfer; after byte 13 transfers, go to PAYLOAD.
  - Requester tready = 0.
- PAYLOAD:
  - Granted requester passes through: temac_tx_tvalid = src tvalid, tdata = src tdata, src tready = temac_tx_tready. Non-granted tready = 0.
  - Gaps in src tvalid are passed through.
  - On transfer of the src tlast byte:
    - If counter + 1 >= MIN_FRAME_BYTES: temac_tx_tlast = 1 on that byte, go to IDLE.
    - Otherwise: temac_tx_tlast = 0, go to PAD.
- PAD:
  - tvalid = 1, tdata = 8'h00, requester tready = 0.
  - tlast = 1 on byte index MIN_FRAME_BYTES-1; after it transfers, go to IDLE.
- Byte counter: 16 bits, counts all transferred bytes including header, saturates at 16'hFFFF.
- Frame counters: on transfer of the temac_tx_tlast byte, increment the count of the owning source (mod 2^16).
- Stall: while temac_tx_tready = 0, tdata/tlast/state hold stable in HEADER and PAD. In PAYLOAD they follow the source, which holds under AXIS rules.
- Back-to-back frames: return to IDLE costs 1 idle cycle between frames.
- Requester tlast asserted on its first payload byte gives a 1-byte payload, padded.
- Lengths above 1500 payload bytes are passed unchecked.

Test Plan:
1. IP request, dest 0x0A0B0C0D0E0F, temac_address 0x020000000001, 46 payload bytes 0x00-0x2D, tready = 1 -> output 0A 0B 0C 0D 0E 0F 02 00 00 00 00 01 08 00 00..2D; tlast on byte 60; no pad; ip_frame_count = 1.
2. ARP request, 28 payload bytes -> EtherType 08 06, 28 payload bytes, then 18 bytes of 0x00; tlast on byte 60; arp_tx_tready = 0 during pad; arp_frame_count = 1.
3. IP and ARP assert tvalid in the same cycle after reset, both continuously requesting -> frame order IP, ARP, IP, ARP; active_source 01/10 accordingly; exactly one idle cycle between frames.
4. temac_tx_tready toggling 1/0 every cycle over case 1 -> byte sequence identical to case 1; tdata/tvalid stable on every stalled cycle.
5. reset asserted while IP byte 20 is pending -> next cycle tvalid = 0, busy = 0, counts = 0; a new ARP frame then starts cleanly with dest MAC byte 0.
6. 1-byte IP payload -> 14 header + 1 payload + 45 pad = 60 bytes. 1500-byte payload -> 1514 bytes, no pad, tlast on byte 1514.
